// File: rtl/mux4_scan_pkg.sv
// Shared state encoding, sizes and the word parity helper for the mux4 scan controller.
package mux4_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int SETTLE_W = 4;
  localparam int NUM_CH   = 4;
  localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);

  function automatic logic word_parity(input logic [NUM_CH-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/scan_settle_cnt.sv
// Loadable down-counter timing the settle wait of each mux channel.
module scan_settle_cnt
  import mux4_scan_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                dec,
  input  logic [SETTLE_W-1:0] load_val,
  output logic                zero
);

  logic [SETTLE_W-1:0] cnt_r;

  // Counter register: load has priority over decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {SETTLE_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec) begin
      cnt_r <= cnt_r - SETTLE_W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {SETTLE_W{1'b0}});

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Scans a downstream 4:1 mux channel by channel and assembles the sampled bits into a word.
// Optional macro MUX4_SCAN_PARITY_EN adds a registered parity output over the word.
module mux4_scan_ctrl
  import mux4_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 32'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  input  logic       out_ready,
  output logic       s1,
  output logic       s0,
  output logic [3:0] word,
  output logic       out_valid,
  output logic       busy
`ifdef MUX4_SCAN_PARITY_EN
  ,
  output logic       parity
`endif
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE);

  state_t     state_r, state_next;
  logic [1:0] sel_r, sel_next;
  logic [3:0] word_r, word_next;
  logic       valid_r;
  logic       busy_r;
  logic       cnt_load_s;
  logic       cnt_dec_s;
  logic       cnt_zero_s;

  scan_settle_cnt u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load_s),
    .dec      (cnt_dec_s),
    .load_val (SETTLE_LOAD),
    .zero     (cnt_zero_s)
  );

  // Next-state, select and word update logic.
  always_comb begin
    state_next = state_r;
    sel_next   = sel_r;
    word_next  = word_r;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SETTLE;
          sel_next   = 2'd0;
          cnt_load_s = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (!cnt_zero_s) begin
          cnt_dec_s = 1'b1;
        end else begin
          word_next[sel_r] = y;
          if (sel_r == LAST_CH) begin
            state_next = ST_DONE;
            sel_next   = 2'd0;
          end else begin
            sel_next   = sel_r + 2'd1;
            cnt_load_s = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_DONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        sel_next   = 2'd0;
      end
    endcase
  end

  // Registered state and outputs; valid and busy decode the upcoming state so they are flop outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      sel_r   <= 2'd0;
      word_r  <= 4'b0000;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next;
      sel_r   <= sel_next;
      word_r  <= word_next;
      valid_r <= (state_next == ST_DONE);
      busy_r  <= (state_next == ST_SETTLE);
    end
  end

`ifdef MUX4_SCAN_PARITY_EN
  logic parity_r;

  // Parity captured together with the final channel sample and held with the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_r <= 1'b0;
    end else if ((state_r == ST_SETTLE) && (state_next == ST_DONE)) begin
      parity_r <= word_parity(word_next);
    end else begin
      parity_r <= parity_r;
    end
  end

  assign parity = parity_r;
`endif

  assign s1        = sel_r[1];
  assign s0        = sel_r[0];
  assign word      = word_r;
  assign out_valid = valid_r;
  assign busy      = busy_r;

endmodule
